// File: rtl/drive_cmd_tx.sv
// -----------------------------------------------------------------------------
// drive_cmd_tx
//   Sends 4-byte drive-command frames over a UART line (8N1, idle high,
//   LSB first):
//     B0 = 0xA5 sync, B1 = {state, cam_state, drive_state} snapshot,
//     B2 = seq, B3 = B0 ^ B1 ^ B2.
//   A frame starts when any of these holds: an update pulse, a pending
//   request, a command that differs from the last-sent snapshot, or the
//   refresh interval running out. Requests that arrive while a frame is on
//   the line are folded into a single follow-on frame.
//
// Parameters
//   CLKS_PER_BIT   clk_50 cycles per UART bit
//   REFRESH_CYCLES maximum clk_50 cycles between frame starts
//
// Ports
//   clk_50       in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   state        in   [1:0] top-level mode (IDLE/CAM/IR)
//   cam_state    in   [1:0] CAM sub-state
//   drive_state  in   [3:0] drive command code
//   update       in   single-cycle send request
//   uart_tx      out  serial line
//   busy         out  high while a frame is on the line
//   seq          out  [7:0] sequence number of the next frame
// -----------------------------------------------------------------------------
module drive_cmd_tx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [1:0] state,
  input  logic [1:0] cam_state,
  input  logic [3:0] drive_state,
  input  logic       update,
  output logic       uart_tx,
  output logic       busy,
  output logic [7:0] seq
);

  localparam int BW = (CLKS_PER_BIT > 1)   ? $clog2(CLKS_PER_BIT)   : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [7:0]    SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  tx_state_e   tx_state_q;
  logic [1:0]  byte_idx_q;
  logic [2:0]  bit_idx_q;
  logic [BW-1:0] baud_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  snap_q;
  logic [7:0]  seq_q;
  logic        pending_q;
  logic [RW-1:0] refresh_q;
  logic        uart_tx_q;
  logic        busy_q;

  logic [7:0]  cmd;
  logic        cmd_changed;
  logic        refresh_due;
  logic        trigger;
  logic        baud_done;
  logic [7:0]  byte_val;

  assign cmd         = {state, cam_state, drive_state};
  assign cmd_changed = (cmd != snap_q);
  assign refresh_due = (refresh_q == REFRESH_LAST);
  assign trigger     = update | pending_q | cmd_changed | refresh_due;
  assign baud_done   = (baud_cnt_q == BAUD_LAST);

  // Byte currently being serialised; snap_q and seq_q are stable for the
  // whole frame, so the checksum is consistent with B1 and B2 on the line.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the default first) so no latch is inferred.
  always_comb begin
    byte_val = SYNC_BYTE;
    case (byte_idx_q)
      2'd0: byte_val = SYNC_BYTE;
      2'd1: byte_val = snap_q;
      2'd2: byte_val = seq_q;
      2'd3: byte_val = SYNC_BYTE ^ snap_q ^ seq_q;
      default: byte_val = SYNC_BYTE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= '0;
      shift_q    <= 8'h00;
      snap_q     <= 8'h00;
      seq_q      <= 8'h00;
      pending_q  <= 1'b1;   // forces a frame on the first edge after reset
      refresh_q  <= '0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // Refresh counter runs freely and saturates; a frame start clears it.
      if (!refresh_due) begin
        refresh_q <= refresh_q + 1'b1;
      end

      // Requests seen while the line is busy collapse into one pending flag.
      if (tx_state_q != TX_IDLE && (update || cmd_changed)) begin
        pending_q <= 1'b1;
      end

      case (tx_state_q)
        TX_IDLE: begin
          uart_tx_q <= 1'b1;
          busy_q    <= 1'b0;
          if (trigger) begin
            snap_q     <= cmd;
            pending_q  <= 1'b0;
            refresh_q  <= '0;
            byte_idx_q <= 2'd0;
            baud_cnt_q <= '0;
            uart_tx_q  <= 1'b0;
            busy_q     <= 1'b1;
            tx_state_q <= TX_START;
          end
        end

        TX_START: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            uart_tx_q  <= byte_val[0];
            shift_q    <= {1'b0, byte_val[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        TX_DATA: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              uart_tx_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              uart_tx_q <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        TX_STOP: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (byte_idx_q == 2'd3) begin
              // Back to idle for one cycle; a pending request restarts on
              // the next edge.
              seq_q      <= seq_q + 8'd1;
              busy_q     <= 1'b0;
              tx_state_q <= TX_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              uart_tx_q  <= 1'b0;
              tx_state_q <= TX_START;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = busy_q;
  assign seq     = seq_q;

endmodule

// File: tb/tb_drive_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_tx
//   Self-checking bench for drive_cmd_tx (CLKS_PER_BIT=4, REFRESH_CYCLES=1000).
//   A reference model tracks frames in terms of "cycles since frame start",
//   and derives the expected line level from the frame bytes by arithmetic
//   on the bit position. Directed scenarios are followed by a random phase.
// -----------------------------------------------------------------------------
module tb_drive_cmd_tx;

  localparam int CPB     = 4;
  localparam int REFRESH = 1000;
  localparam int FRAME   = 40 * CPB;

  logic       clk_50 = 1'b0;
  logic       reset_n;
  logic [1:0] st;
  logic [1:0] cs;
  logic [3:0] ds;
  logic       upd;
  logic       uart_tx;
  logic       busy;
  logic [7:0] seq;

  drive_cmd_tx #(
    .CLKS_PER_BIT   (CPB),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .state       (st),
    .cam_state   (cs),
    .drive_state (ds),
    .update      (upd),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .seq         (seq)
  );

  always #5 clk_50 = ~clk_50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy;
  int         m_k;       // cycles since frame start edge
  logic [7:0] m_snap;
  logic [7:0] m_seq;
  bit         m_pend;
  int         m_ref;
  bit         frame_done;
  int         frames_done = 0;

  function automatic logic [7:0] frame_byte(input int b);
    case (b)
      0:       return 8'hA5;
      1:       return m_snap;
      2:       return m_seq;
      default: return 8'hA5 ^ m_snap ^ m_seq;
    endcase
  endfunction

  function automatic logic exp_tx();
    int p, b, r;
    logic [7:0] v;
    if (!m_busy) return 1'b1;
    p = m_k / CPB;
    b = p / 10;
    r = p % 10;
    v = frame_byte(b);
    if (r == 0) return 1'b0;
    if (r == 9) return 1'b1;
    return v[r-1];
  endfunction

  task automatic m_reset();
    m_busy = 0; m_k = 0; m_snap = 8'h00; m_seq = 8'h00; m_pend = 1; m_ref = 0;
  endtask

  task automatic model_edge();
    logic [7:0] cur;
    frame_done = 0;
    if (!reset_n) begin
      m_reset();
      return;
    end
    cur = {st, cs, ds};
    if (m_busy) begin
      if (upd || cur != m_snap) m_pend = 1;
      m_k++;
      if (m_k == FRAME) begin
        m_busy = 0;
        m_seq  = m_seq + 8'd1;
        frame_done = 1;
      end
      m_ref = (m_ref >= REFRESH - 1) ? REFRESH - 1 : m_ref + 1;
    end else if (upd || m_pend || cur != m_snap || m_ref == REFRESH - 1) begin
      m_busy = 1; m_k = 0; m_snap = cur; m_pend = 0; m_ref = 0;
    end else begin
      m_ref = (m_ref >= REFRESH - 1) ? REFRESH - 1 : m_ref + 1;
    end
  endtask

  // ---------------- observation ----------------
  logic       line_hist [0:FRAME-1];
  logic [7:0] last_frame [0:3];
  int         cyc = 0;
  int         n_starts = 0;
  int         last_start = 0;
  int         n_busy_cyc = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_seq = 8'h00;
  bit         saw_wrap = 0;

  task automatic decode_frame();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        last_frame[b][i] = line_hist[(b * 10 + 1 + i) * CPB + CPB / 2];
  endtask

  // One clock: model the coming edge with the current inputs, then sample
  // the DUT on the falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk_50);
    @(negedge clk_50);
    cyc++;
    check("uart_tx", uart_tx, exp_tx());
    check("busy", busy, m_busy);
    check("seq", seq, m_seq);
    if (m_busy) line_hist[m_k] = uart_tx;
    if (busy && !prev_busy) begin
      n_starts++;
      last_start = cyc;
    end
    if (busy) n_busy_cyc++;
    if (prev_seq == 8'hFF && seq == 8'h00) saw_wrap = 1;
    prev_busy = busy;
    prev_seq  = seq;
    if (frame_done) begin
      frames_done++;
      decode_frame();
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!m_busy) return;
      tick();
    end
    check("timeout_idle", 0, 1);
  endtask

  task automatic wait_k(input int k, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_busy && m_k == k) return;
      tick();
    end
    check("timeout_k", 0, 1);
  endtask

  task automatic wait_start(input int limit, output int t);
    int n0;
    n0 = n_starts;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (n_starts != n0) begin
        t = last_start;
        return;
      end
    end
    check("timeout_start", 0, 1);
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs react at once.
  task automatic async_reset(input int hold);
    reset_n = 1'b0;
    #1;
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_seq", seq, 8'h00);
    m_reset();
    @(negedge clk_50);
    prev_busy = busy;
    prev_seq  = seq;
    repeat (hold) tick();
    reset_n = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp);
    check(tag, {last_frame[0], last_frame[1], last_frame[2], last_frame[3]}, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1, t2, n0, b0, f0;
    logic [7:0] s0;

    reset_n = 1'b0;
    st = 2'b00; cs = 2'b00; ds = 4'b0000; upd = 1'b0;
    m_reset();
    @(negedge clk_50);
    repeat (3) tick();

    // Frame right after reset release with all-zero command.
    reset_n = 1'b1;
    b0 = n_busy_cyc;
    tick();
    check("first_start", busy, 1'b1);
    wait_idle(FRAME + 10);
    check("first_busy_len", n_busy_cyc - b0, FRAME);
    check_frame("first_frame", 32'hA5_00_00_A5);
    check("first_seq", seq, 8'h01);

    // Idle, then a command change starts a frame on the sampling edge.
    repeat (20) tick();
    st = 2'b01; cs = 2'b01; ds = 4'b0100;
    tick();
    check("chg_start", busy, 1'b1);
    wait_idle(FRAME + 10);
    check_frame("chg_frame", 32'hA5_54_01_F0);

    // Command change during B1: current frame keeps snapshot, follow-on
    // frame starts one cycle after the current one ends.
    repeat (5) tick();
    pulse_update();
    wait_k(50, FRAME);
    ds = 4'b0001;
    wait_idle(FRAME + 10);
    check_frame("frozen_frame", 32'hA5_54_02_F3);
    check("gap_idle", busy, 1'b0);
    tick();
    check("followon_start", busy, 1'b1);
    wait_idle(FRAME + 10);
    check_frame("followon_frame", 32'hA5_51_03_F7);

    // Three update pulses in one frame give exactly one follow-on frame.
    repeat (5) tick();
    pulse_update();
    n0 = n_starts;
    wait_k(20, FRAME);  pulse_update();
    wait_k(60, FRAME);  pulse_update();
    wait_k(100, FRAME); pulse_update();
    repeat (600) tick();
    check("followon_count", n_starts - n0, 1);

    // Refresh period with static inputs.
    wait_start(1200, t1);
    wait_start(1200, t2);
    check("refresh_period", t2 - t1, REFRESH);

    // Back-to-back frames until seq wraps all the way around.
    wait_idle(FRAME + 10);
    s0 = m_seq;
    f0 = frames_done;
    upd = 1'b1;
    for (int i = 0; i < 256 * (FRAME + 1) + 50; i++) begin
      if (frames_done - f0 >= 256) break;
      tick();
    end
    upd = 1'b0;
    check("wrap_frames", frames_done - f0, 256);
    check("seq_wrap", seq, s0);
    check("seq_wrap_seen", saw_wrap, 1'b1);

    // Reset 50 cycles into a frame; fresh frame with seq 0 after release.
    wait_idle(FRAME + 10);
    tick();
    pulse_update();
    wait_k(50, FRAME);
    st = 2'b01; cs = 2'b01; ds = 4'b0100;
    async_reset(3);
    tick();
    check("post_rst_start", busy, 1'b1);
    wait_idle(FRAME + 10);
    check_frame("post_rst_frame", 32'hA5_54_00_F1);

    // Random phase.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        st = 2'($urandom); cs = 2'($urandom); ds = 4'($urandom);
      end
      upd = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3999) == 0) begin
        upd = 1'b0;
        async_reset(2);
      end
      tick();
    end
    upd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
